// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module  : serial_add_pkg
// Brief   : Shared state encoding and default width for the bit-serial adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  localparam int C_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/half_adder_cell.sv
// ============================================================================
// Module  : half_adder_cell
// Brief   : Combinational half adder; two of these plus an OR make a full adder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

`default_nettype wire

// File: rtl/serial_add_engine.sv
// ============================================================================
// Module  : serial_add_engine
// Brief   : LSB-first bit-serial adder with valid/ready on operands and result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_engine
  import serial_add_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic w_s0;
  logic w_c0;
  logic w_s;
  logic w_c1;
  logic w_c;

  half_adder_cell u_ha0 (
    .x (r_a_sr[0]),
    .y (r_b_sr[0]),
    .s (w_s0),
    .c (w_c0)
  );

  half_adder_cell u_ha1 (
    .x (w_s0),
    .y (r_carry),
    .s (w_s),
    .c (w_c1)
  );

  assign w_c = w_c0 | w_c1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)        w_next_state = RUN;
      RUN:     if (r_cnt == C_LAST) w_next_state = DONE;
      DONE:    if (out_ready)       w_next_state = IDLE;
      default:                      w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
          r_carry  <= w_c;
          r_cnt    <= r_cnt + CW'(1);
        end
        DONE: begin
          // Snapshot the result so it keeps showing after the working
          // registers are reloaded by the next operand.
          if (out_ready) begin
            r_sum  <= r_sum_sr;
            r_cout <= r_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);
  assign sum       = (r_state == DONE) ? r_sum_sr : r_sum;
  assign cout      = (r_state == DONE) ? r_carry  : r_cout;

endmodule

`default_nettype wire
